// File: rtl/cpu_peripheral_pkg.sv
// cpu_peripheral_pkg
//   Shared types and constants for the CPU peripheral slice: the UART RX
//   state encoding, the bus register map and the STATUS bit positions.
package cpu_peripheral_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [1:0] ADDR_RXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_LEDS   = 2'd2;
  localparam logic [1:0] ADDR_IE     = 2'd3;

  localparam int ST_RX_READY   = 0;
  localparam int ST_FRAME_ERR  = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_PARITY_ERR = 3;

endpackage

// File: rtl/cpu_peripheral_uart_rx.sv
// uart_rx
//   UART receiver: 2-flop synchronizer on the RX line, RX state machine and
//   LSB-first shift register. Reports each frame with one-cycle pulses.
//   Optional: define UART_PARITY_EN for 8E1 frames (even parity bit after
//   the data bits); otherwise 8N1.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx                asynchronous UART line, idle high
//   data              last good byte, valid with the valid pulse
//   valid             one-cycle pulse: good frame received
//   frame_err         one-cycle pulse: stop bit sampled low
//   parity_err        one-cycle pulse: parity mismatch (0 without UART_PARITY_EN)
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronized line
// START  | timing to mid start bit, rejecting glitches
// DATA   | sampling DATA_W bits at mid-bit, LSB first
// PARITY | sampling the even-parity bit (UART_PARITY_EN only)
// STOP   | sampling the stop bit and reporting the frame
module uart_rx
  import cpu_peripheral_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t         state;
  logic [1:0]        sync_q;
  logic              line;
  logic              line_d;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic              par_bad;

  assign line = sync_q[1];

  // Timers are down-counters; each phase acts when cnt reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      line_d     <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_bad    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      line_d     <= line;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          if (line_d && !line) begin
            state <= START;
            cnt   <= CNT_HALF;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!line) begin
            state   <= DATA;
            cnt     <= CNT_FULL;
            bit_cnt <= BIT_W'(DATA_W - 1);
            par_bad <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shift_q <= {line, shift_q[DATA_W-1:1]};
            cnt     <= CNT_FULL;
            if (bit_cnt == '0) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt - BIT_W'(1);
            end
          end
        end
        PARITY: begin
`ifdef UART_PARITY_EN
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Even parity: data bits plus parity bit must XOR to zero.
            par_bad <= ^{shift_q, line};
            cnt     <= CNT_FULL;
            state   <= STOP;
          end
`else
          state <= IDLE;
`endif
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= IDLE;
            if (!line) begin
              frame_err <= 1'b1;
            end else if (par_bad) begin
              parity_err <= 1'b1;
            end else begin
              data  <= shift_q;
              valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_peripheral.sv
// cpu_peripheral
//   Peripheral subsystem beside the MIPS core: UART receiver, LED register,
//   interrupt line and a 4-entry memory-mapped register port.
//   Optional: UART_PARITY_EN selects 8E1 reception and enables STATUS bit 3.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   uart_in      UART RX line, idle high
//   bus_addr     register select (RXDATA, STATUS, LEDS, IE)
//   bus_re       read strobe; an RXDATA read clears rx_ready
//   bus_we       write strobe
//   bus_wdata    write data
//   bus_rdata    read data, combinational from bus_addr, zero-extended
//   leds         LED register
//   int0         level interrupt, rx_ready & ie, registered
module cpu_peripheral
  import cpu_peripheral_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_in,
  input  logic [1:0]        bus_addr,
  input  logic              bus_re,
  input  logic              bus_we,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic [DATA_W-1:0] leds,
  output logic              int0
);

  logic [DATA_W-1:0] rx_byte;
  logic              rx_valid;
  logic              rx_frame_err;
  logic              rx_parity_err;

  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic              frame_err;
  logic              overrun;
  logic              parity_err;
  logic              ie;

  logic rd_rxdata;
  logic wr_status;
  logic wr_leds;
  logic wr_ie;
  logic unused_wdata;

  assign rd_rxdata    = bus_re && (bus_addr == ADDR_RXDATA);
  assign wr_status    = bus_we && (bus_addr == ADDR_STATUS);
  assign wr_leds      = bus_we && (bus_addr == ADDR_LEDS);
  assign wr_ie        = bus_we && (bus_addr == ADDR_IE);
  assign unused_wdata = ^bus_wdata[31:DATA_W];

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_W      (DATA_W)
  ) u_uart_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_in),
    .data      (rx_byte),
    .valid     (rx_valid),
    .frame_err (rx_frame_err),
    .parity_err(rx_parity_err)
  );

  // Hardware set events take priority over bus clears and LED writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_ready   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      ie         <= 1'b1;
      leds       <= '0;
      int0       <= 1'b0;
    end else begin
      if (rx_valid) begin
        rx_data  <= rx_byte;
        leds     <= rx_byte;
        rx_ready <= 1'b1;
      end else begin
        if (rd_rxdata) rx_ready <= 1'b0;
        if (wr_leds)   leds     <= bus_wdata[DATA_W-1:0];
      end

      if (rx_valid && rx_ready)
        overrun <= 1'b1;
      else if (wr_status && bus_wdata[ST_OVERRUN])
        overrun <= 1'b0;

      if (rx_frame_err)
        frame_err <= 1'b1;
      else if (wr_status && bus_wdata[ST_FRAME_ERR])
        frame_err <= 1'b0;

      if (rx_parity_err)
        parity_err <= 1'b1;
      else if (wr_status && bus_wdata[ST_PARITY_ERR])
        parity_err <= 1'b0;

      if (wr_ie) ie <= bus_wdata[0];

      int0 <= rx_ready & ie;
    end
  end

  always_comb begin
    bus_rdata = 32'h0;
    case (bus_addr)
      ADDR_RXDATA: bus_rdata = {{(32-DATA_W){1'b0}}, rx_data};
      ADDR_STATUS: bus_rdata = {28'h0, parity_err, overrun, frame_err, rx_ready};
      ADDR_LEDS:   bus_rdata = {{(32-DATA_W){1'b0}}, leds};
      ADDR_IE:     bus_rdata = {31'h0, ie};
      default:     bus_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cpu_peripheral.sv
// tb_cpu_peripheral
//   Self-checking bench for cpu_peripheral (8N1, 10 clocks per bit,
//   20 ns clock). Expected bytes are queued as frames are sent and popped
//   when the received byte is checked.
module tb_cpu_peripheral;
  import cpu_peripheral_pkg::*;

  localparam int BIT_NS = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_in = 1'b1;
  logic [1:0]  bus_addr = 2'd0;
  logic        bus_re = 1'b0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic [7:0]  leds;
  logic        int0;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #10 clk = ~clk;

  cpu_peripheral #(
    .CLKS_PER_BIT(10),
    .DATA_W      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_in  (uart_in),
    .bus_addr (bus_addr),
    .bus_re   (bus_re),
    .bus_we   (bus_we),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .leds     (leds),
    .int0     (int0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus tasks start and end on a falling clock edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_addr = a;
    bus_re   = 1'b1;
    #1 d = bus_rdata;
    @(negedge clk);
    bus_re   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_in = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      #BIT_NS;
    end
    uart_in = stop_bit;
    #BIT_NS;
    uart_in = 1'b1;
    if (stop_bit) exp_q.push_back(b);
  endtask

  task automatic check_rx(input string tag, output logic [7:0] e);
    e = 8'h00;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(leds), 32'(e));
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  e;

    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    check("rst_leds", 32'(leds), 32'h0);
    check("rst_int0", 32'(int0), 32'h0);
    bus_read(ADDR_STATUS, rd);
    check("rst_status", rd, 32'h0);
    bus_read(ADDR_IE, rd);
    check("rst_ie", rd, 32'h1);
    bus_read(ADDR_RXDATA, rd);
    check("rst_rxdata", rd, 32'h0);

    while ($time < 500) @(negedge clk);

    // First frame
    send_frame(8'h55, 1'b1);
    #1000;
    check_rx("leds_55", e);
    bus_read(ADDR_STATUS, rd);
    check("status_ready_55", rd, 32'h1);
    check("int0_set_55", 32'(int0), 32'h1);
    bus_read(ADDR_RXDATA, rd);
    check("rxdata_55", rd, 32'(e));
    @(negedge clk);
    check("int0_drop_after_read", 32'(int0), 32'h0);

    // Second frame
    send_frame(8'hC8, 1'b1);
    #1000;
    check_rx("leds_c8", e);
    bus_read(ADDR_RXDATA, rd);
    check("rxdata_c8", rd, 32'(e));

    // Framing error
    send_frame(8'hA5, 1'b0);
    #1000;
    bus_read(ADDR_STATUS, rd);
    check("status_frame_err", rd, 32'h2);
    check("leds_kept_on_ferr", 32'(leds), 32'hC8);
    check("int0_kept_on_ferr", 32'(int0), 32'h0);
    bus_write(ADDR_STATUS, 32'h2);
    bus_read(ADDR_STATUS, rd);
    check("status_ferr_cleared", rd, 32'h0);

    // Overrun
    send_frame(8'h12, 1'b1);
    #1000;
    check_rx("leds_12", e);
    send_frame(8'h34, 1'b1);
    #1000;
    check_rx("leds_34", e);
    bus_read(ADDR_STATUS, rd);
    check("status_overrun", rd, 32'h5);
    bus_read(ADDR_RXDATA, rd);
    check("rxdata_second", rd, 32'(e));
    bus_write(ADDR_STATUS, 32'h4);
    bus_read(ADDR_STATUS, rd);
    check("status_ovr_cleared", rd, 32'h0);

    // Glitch on the line
    uart_in = 1'b0;
    #60;
    uart_in = 1'b1;
    #1000;
    bus_read(ADDR_STATUS, rd);
    check("status_after_glitch", rd, 32'h0);
    check("leds_after_glitch", 32'(leds), 32'h34);
    check("int0_after_glitch", 32'(int0), 32'h0);

    // LED write
    bus_write(ADDR_LEDS, 32'hFFFF_FF3C);
    check("leds_write", 32'(leds), 32'h3C);
    bus_read(ADDR_LEDS, rd);
    check("leds_readback", rd, 32'h3C);

    // Interrupt masking
    bus_write(ADDR_IE, 32'h0);
    send_frame(8'h9A, 1'b1);
    #1000;
    check_rx("leds_9a", e);
    bus_read(ADDR_STATUS, rd);
    check("status_ready_masked", rd, 32'h1);
    check("int0_masked", 32'(int0), 32'h0);
    bus_read(ADDR_IE, rd);
    check("ie_readback_0", rd, 32'h0);
    bus_write(ADDR_IE, 32'h1);
    check("int0_lag", 32'(int0), 32'h0);
    @(negedge clk);
    check("int0_unmasked", 32'(int0), 32'h1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_peripheral.md
Name: cpu_peripheral

Overview:
- Peripheral subsystem beside the MIPS core: UART receiver, LED output register, interrupt line to the core, and a small memory-mapped register port for the core.
- Each correctly framed byte received on uart_in is written to the LED register and raises int0.
- The MIPS core is a separate block and connects through the bus port.

Parameters:
- CLKS_PER_BIT, 10: clock cycles per UART bit (50 MHz clk, 5 Mbaud, 200 ns bit).
- DATA_W, 8: UART data bits per frame (also LED width).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_in  in  1  UART RX line; idle high; 8N1; LSB first.
- bus_addr  in  2  register select.
- bus_re  in  1  read strobe, one cycle.
- bus_we  in  1  write strobe, one cycle.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, combinational from bus_addr.
- leds  out  DATA_W  LED register.
- int0  out  1  interrupt to core, level, active-high.

Behaviour:
- Reset values: leds=0, int0=0, rx_data=0, rx_ready=0, frame_err=0, overrun=0, ie=1. The RX state machine goes to IDLE.
- uart_in input path:
  - Passes through a 2-flop synchronizer before any use.
  - The synchronizer resets to 1.
- RX state machine:
  - IDLE: a falling edge on the synchronized line moves to START with the counter cleared.
  - START: at count CLKS_PER_BIT/2, if the line is low, go to DATA. If the line is high, treat it as a glitch and return to IDLE with no flags changed.
  - DATA: sample every CLKS_PER_BIT cycles from mid-bit. Shift in LSB first. After DATA_W samples, go to STOP.
  - STOP: sample at mid-bit.
    - Stop bit = 1: commit the byte. In the same cycle, rx_data and leds take the byte, and rx_ready is set.
    - Stop bit = 0: set frame_err and discard the byte.
    - Either way, return to IDLE.
- Commit latency: leds updates within CLKS_PER_BIT cycles after the stop-bit midpoint (plus 2 synchronizer cycles).
- Overrun: a commit while rx_ready=1 sets overrun, overwrites rx_data, and leaves rx_ready at 1.
- int0 = rx_ready & ie, registered, one cycle after rx_ready changes.
- Register map (bus_rdata is zero-extended):
  - 0 RXDATA, read-only. A read with bus_re clears rx_ready.
  - 1 STATUS {overrun, frame_err, rx_ready} at bits [2:0]. Writing 1 to bit 1 clears frame_err; writing 1 to bit 2 clears overrun.
  - 2 LEDS, R/W. A write loads bus_wdata[DATA_W-1:0].
  - 3 IE, R/W at bit 0.
- Simultaneous events:
  - Commit in the same cycle as an RXDATA read: rx_ready stays 1, and the new byte is visible on the next read.
  - Commit in the same cycle as a LEDS write: the received byte wins.
  - Status-bit set and write-1-clear in the same cycle: set wins.
- rst asserted mid-frame aborts the frame; no commit occurs.
- Reads with bus_re low have no side effects.

Optional Feature:
- UART_PARITY_EN defined:
  - The frame becomes 8E1: an even-parity bit follows the data bits, and a PARITY state sits between DATA and STOP.
  - On parity mismatch, set STATUS bit 3 parity_err and discard the byte. STATUS bit 3 is cleared by writing 1 to it.
- UART_PARITY_EN undefined: 8N1 only, and STATUS bit 3 reads 0.

Decomposition:
- Package cpu_peripheral_pkg holds:
  - The RX state enum (IDLE, START, DATA, PARITY, STOP).
  - Register address constants (ADDR_RXDATA=0, ADDR_STATUS=1, ADDR_LEDS=2, ADDR_IE=3).
  - STATUS bit indices.
- One sub-module, uart_rx, contains the synchronizer, state machine and shift register. Its outputs are a byte, a one-cycle valid pulse, and a one-cycle framing/parity error pulse.
- The top level holds the registers, the bus decode and int0.

Test Plan:
- Reset: assert rst for 4 cycles -> leds=0x00, int0=0, all STATUS bits 0, IE reads 1.
- Frame 0x55: at 500 ns, drive start 0, then bits 1,0,1,0,1,0,1,0, then stop 1, each 200 ns -> 1000 ns after the stop bit, leds=0x55, rx_ready=1, int0=1.
- Frame 0xC8: read RXDATA (int0 drops), then drive start, bits 0,0,0,1,0,0,1,1, stop 1 -> leds=0xC8, RXDATA reads 0xC8.
- Framing error: send 0xA5 with stop bit 0 -> frame_err=1, leds unchanged, int0 unchanged. Write 0x2 to STATUS -> frame_err=0.
- Overrun and glitch:
  - Send two bytes without reading -> overrun=1 and RXDATA holds the second byte.
  - A 60 ns low pulse on uart_in -> no state or flag change.
- Bus and interrupt control:
  - Write 0x3C to LEDS -> leds=0x3C.
  - Write IE=0, then receive a byte -> int0 stays 0 and rx_ready=1.
  - Write IE=1 -> int0=1 on the next cycle.
